vga_rx_monitor: RTL and testbench

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

---
 rtl/vga_rx_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: VGA receive capture with timing lock and frame error tracking.
// Define VGA_RX_FRAME_SUM_EN to build the per-frame {B,G,R} checksum on oFRAME_SUM.
module vga_rx_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [7:0]  iB,
    input  logic [7:0]  iG,
    input  logic [7:0]  iR,
    output logic        oPIX_VALID,
    output logic [23:0] oPIX_DATA,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oFRAME_DONE,
    output logic        oLOCKED,
    output logic        oERR,
    output logic [7:0]  oERR_CNT,
    output logic [31:0] oFRAME_SUM
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [9:0] XY_MAX = 10'd1023;

    logic        hs1_q, hs1_d, hs2_q, hs2_d;
    logic        vs1_q, vs1_d, vs2_q, vs2_d;
    logic        bl1_q, bl1_d, bl2_q, bl2_d;
    logic [23:0] pix1_q, pix1_d;

    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        bad_q, bad_d;
    logic [3:0]  good_q, good_d;
    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        done_q, done_d;
    logic        pv_q, pv_d;
    logic [23:0] pd_q, pd_d;
    logic [9:0]  ox_q, ox_d, oy_q, oy_d;

    logic        line_end, frame_start, line_bad, frame_bad;
    logic [9:0]  x_inc, y_inc, y_end;
    logic [3:0]  good_inc;
    logic        unused_hs;

    // HS is captured alongside VS/BLANK but nothing downstream needs it.
    assign unused_hs = hs1_q ^ hs2_q;

    always_comb begin
        hs1_d  = iHS;
        vs1_d  = iVS;
        bl1_d  = iBLANK_n;
        pix1_d = {iB, iG, iR};
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        bl2_d  = bl1_q;

        line_end    = bl2_q & ~bl1_q;
        frame_start = vs2_q & ~vs1_q;
        x_inc       = (x_q == XY_MAX) ? XY_MAX : x_q + 10'd1;
        y_inc       = (y_q == XY_MAX) ? XY_MAX : y_q + 10'd1;
        line_bad    = line_end & (x_q != H_ACT);
        // A coincident line end belongs to the frame that is ending.
        y_end       = line_end ? y_inc : y_q;
        frame_bad   = bad_q | line_bad | (y_end != V_ACT);

        x_d = x_q;
        if (line_end) begin
            x_d = 10'd0;
        end else if (bl1_q) begin
            x_d = x_inc;
        end

        y_d = y_q;
        if (frame_start) begin
            y_d = 10'd0;
        end else if (line_end) begin
            y_d = y_inc;
        end

        bad_d = bad_q;
        if (frame_start) begin
            bad_d = 1'b0;
        end else if (line_bad) begin
            bad_d = 1'b1;
        end

        pv_d   = bl1_q & (state_q != SEARCH);
        pd_d   = pv_d ? pix1_q : pd_q;
        ox_d   = pv_d ? x_q : ox_q;
        oy_d   = pv_d ? y_q : oy_q;
        done_d = frame_start & (state_q != SEARCH);
    end

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        good_inc  = good_q + 4'd1;
        if (frame_start) begin
            unique case (state_q)
                SEARCH: begin
                    state_d = MEASURE;
                    good_d  = 4'd0;
                end
                MEASURE: begin
                    if (frame_bad) begin
                        good_d = 4'd0;
                    end else begin
                        good_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (frame_bad) begin
                        state_d   = SEARCH;
                        good_d    = 4'd0;
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF
                                                         : err_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs1_q     <= 1'b1;
            hs2_q     <= 1'b1;
            vs1_q     <= 1'b1;
            vs2_q     <= 1'b1;
            bl1_q     <= 1'b1;
            bl2_q     <= 1'b1;
            pix1_q    <= 24'd0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            bad_q     <= 1'b0;
            pv_q      <= 1'b0;
            pd_q      <= 24'd0;
            ox_q      <= 10'd0;
            oy_q      <= 10'd0;
            done_q    <= 1'b0;
        end else begin
            hs1_q     <= hs1_d;
            hs2_q     <= hs2_d;
            vs1_q     <= vs1_d;
            vs2_q     <= vs2_d;
            bl1_q     <= bl1_d;
            bl2_q     <= bl2_d;
            pix1_q    <= pix1_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bad_q     <= bad_d;
            pv_q      <= pv_d;
            pd_q      <= pd_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            good_q    <= 4'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef VGA_RX_FRAME_SUM_EN
    logic [31:0] acc_q, acc_d, fsum_q, fsum_d, pix_term;

    always_comb begin
        pix_term = bl1_q ? {8'd0, pix1_q} : 32'd0;
        acc_d    = frame_start ? pix_term : acc_q + pix_term;
        fsum_d   = done_d ? acc_q : fsum_q;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            acc_q  <= 32'd0;
            fsum_q <= 32'd0;
        end else begin
            acc_q  <= acc_d;
            fsum_q <= fsum_d;
        end
    end

    assign oFRAME_SUM = fsum_q;
`else
    assign oFRAME_SUM = 32'd0;
`endif

    assign oPIX_VALID  = pv_q;
    assign oPIX_DATA   = pd_q;
    assign oX          = ox_q;
    assign oY          = oy_q;
    assign oFRAME_DONE = done_q;
    assign oLOCKED     = (state_q == LOCKED);
    assign oERR        = err_q;
    assign oERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed frames on a reduced 16x10 raster.
// Frame-sum expectations follow VGA_RX_FRAME_SUM_EN.
module tb_vga_rx_monitor;

    localparam int H = 16;
    localparam int V = 10;
`ifdef VGA_RX_FRAME_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        iHS = 1'b1;
    logic        iVS = 1'b1;
    logic        iBLANK_n = 1'b0;
    logic [7:0]  iB = 8'd0;
    logic [7:0]  iG = 8'd0;
    logic [7:0]  iR = 8'd0;
    logic        oPIX_VALID;
    logic [23:0] oPIX_DATA;
    logic [9:0]  oX, oY;
    logic        oFRAME_DONE, oLOCKED, oERR;
    logic [7:0]  oERR_CNT;
    logic [31:0] oFRAME_SUM;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    int pv_total = 0;
    int drv_cyc = 0;
    int got_cyc = 0;
    int p = 0;
    logic [9:0]  last_x = 10'd0;
    logic        arm = 1'b0;
    logic        seen = 1'b0;
    logic [23:0] got_data = 24'd0;
    logic        v_done, v_lock, v_err;
    logic [7:0]  v_cnt;
    logic [31:0] v_sum;

    vga_rx_monitor #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(vga_clk),
        .reset(reset),
        .iHS(iHS),
        .iVS(iVS),
        .iBLANK_n(iBLANK_n),
        .iB(iB),
        .iG(iG),
        .iR(iR),
        .oPIX_VALID(oPIX_VALID),
        .oPIX_DATA(oPIX_DATA),
        .oX(oX),
        .oY(oY),
        .oFRAME_DONE(oFRAME_DONE),
        .oLOCKED(oLOCKED),
        .oERR(oERR),
        .oERR_CNT(oERR_CNT),
        .oFRAME_SUM(oFRAME_SUM)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc_n <= cyc_n + 1;

    always @(negedge vga_clk) begin
        if (oPIX_VALID === 1'b1) begin
            pv_total = pv_total + 1;
            last_x = oX;
            if (arm && !seen && oX == 10'd5 && oY == 10'd7) begin
                seen = 1'b1;
                got_data = oPIX_DATA;
                got_cyc = cyc_n;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v);
        return SUM_EN ? v : 32'd0;
    endfunction

    task automatic clk1();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic blank(input int n);
        iBLANK_n = 1'b0;
        iHS = 1'b1;
        repeat (n) clk1();
    endtask

    task automatic send_line(input int npix, input logic [23:0] base,
                             input int ly);
        for (int i = 0; i < 4; i++) begin
            iBLANK_n = 1'b0;
            iHS = (i < 2) ? 1'b0 : 1'b1;
            clk1();
        end
        iHS = 1'b1;
        for (int x = 0; x < npix; x++) begin
            logic [23:0] v;
            v = base;
            if (arm && ly == 7 && x == 5) begin
                v = 24'hABCDEF;
                drv_cyc = cyc_n;
            end
            iBLANK_n = 1'b1;
            {iB, iG, iR} = v;
            clk1();
        end
    endtask

    // With coincident set the last line's end lands on the next vsync.
    task automatic send_frame(input logic [23:0] base, input int short_ly,
                              input int short_n, input bit coincident);
        for (int l = 0; l < V; l++) begin
            send_line((l == short_ly) ? short_n : H, base, l);
        end
        if (!coincident) blank(4);
    endtask

    task automatic vsync();
        iVS = 1'b0;
        iBLANK_n = 1'b0;
        iHS = 1'b1;
        clk1();
        clk1();
        v_done = oFRAME_DONE;
        v_lock = oLOCKED;
        v_err  = oERR;
        v_cnt  = oERR_CNT;
        v_sum  = oFRAME_SUM;
        clk1();
        iVS = 1'b1;
        repeat (3) clk1();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) clk1();
        check("rst_valid", 32'(oPIX_VALID), 32'd0);
        check("rst_data", 32'(oPIX_DATA), 32'd0);
        check("rst_x", 32'(oX), 32'd0);
        check("rst_y", 32'(oY), 32'd0);
        check("rst_done", 32'(oFRAME_DONE), 32'd0);
        check("rst_lock", 32'(oLOCKED), 32'd0);
        check("rst_err", 32'(oERR), 32'd0);
        check("rst_cnt", 32'(oERR_CNT), 32'd0);
        check("rst_sum", oFRAME_SUM, 32'd0);
        reset = 1'b0;
        clk1();

        p = pv_total;
        send_line(H, 24'h0000FF, 0);
        send_line(H, 24'h0000FF, 1);
        blank(4);
        check("search_pix", 32'(pv_total - p), 32'd0);

        vsync();
        check("fs1_done", 32'(v_done), 32'd0);
        check("fs1_lock", 32'(v_lock), 32'd0);

        p = pv_total;
        send_frame(24'h0000FF, -1, 0, 1'b0);
        vsync();
        check("f1_pix", 32'(pv_total - p), 32'(H * V));
        check("fs2_done", 32'(v_done), 32'd1);
        check("fs2_lock", 32'(v_lock), 32'd0);
        check("fs2_sum", v_sum, sx(32'd40800));

        p = pv_total;
        send_frame(24'h0000FF, -1, 0, 1'b0);
        vsync();
        check("f2_pix", 32'(pv_total - p), 32'(H * V));
        check("fs3_lock", 32'(v_lock), 32'd1);
        check("fs3_err", 32'(v_err), 32'd0);
        check("fs3_cnt", 32'(v_cnt), 32'd0);
        check("fs3_done", 32'(v_done), 32'd1);

        arm = 1'b1;
        send_frame(24'h000001, -1, 0, 1'b0);
        arm = 1'b0;
        vsync();
        check("px_seen", 32'(seen), 32'd1);
        check("px_data", 32'(got_data), 32'hABCDEF);
        check("px_latency", 32'(got_cyc - drv_cyc), 32'd2);
        check("fs4_sum", v_sum, sx(32'hABCDEF + 32'd159));
        check("fs4_lock", 32'(v_lock), 32'd1);

        send_frame(24'h000001, -1, 0, 1'b0);
        vsync();
        check("fs5_sum", v_sum, sx(32'(H * V)));
        check("fs5_done", 32'(v_done), 32'd1);

        send_frame(24'h000001, -1, 0, 1'b1);
        vsync();
        check("coinc_lock", 32'(v_lock), 32'd1);
        check("coinc_err", 32'(v_err), 32'd0);

        send_frame(24'h0000FF, 3, H - 1, 1'b0);
        vsync();
        check("short_lock", 32'(v_lock), 32'd0);
        check("short_err", 32'(v_err), 32'd1);
        check("short_cnt", 32'(v_cnt), 32'd1);
        check("short_done", 32'(v_done), 32'd1);

        p = pv_total;
        send_frame(24'h0000FF, -1, 0, 1'b0);
        check("search2_pix", 32'(pv_total - p), 32'd0);
        vsync();
        check("fs8_done", 32'(v_done), 32'd0);

        p = pv_total;
        send_line(1030, 24'h000001, 0);
        blank(3);
        check("sat_pix", 32'(pv_total - p), 32'd1030);
        check("sat_x", 32'(last_x), 32'd1023);
        for (int l = 1; l < V; l++) send_line(H, 24'h000001, l);
        blank(4);
        vsync();
        check("meas_done", 32'(v_done), 32'd1);
        check("meas_err", 32'(v_err), 32'd1);
        check("meas_cnt", 32'(v_cnt), 32'd1);
        check("meas_lock", 32'(v_lock), 32'd0);

        for (int l = 0; l < 5; l++) send_line(H, 24'h0000FF, l);
        blank(4);
        for (int x = 0; x < 8; x++) begin
            iBLANK_n = 1'b1;
            {iB, iG, iR} = 24'h0000FF;
            clk1();
        end
        reset = 1'b1;
        #1;
        check("mid_valid", 32'(oPIX_VALID), 32'd0);
        check("mid_data", 32'(oPIX_DATA), 32'd0);
        check("mid_x", 32'(oX), 32'd0);
        check("mid_err", 32'(oERR), 32'd0);
        check("mid_cnt", 32'(oERR_CNT), 32'd0);
        clk1();
        clk1();
        reset = 1'b0;
        p = pv_total;
        for (int x = 11; x < H; x++) clk1();
        for (int l = 6; l < V; l++) send_line(H, 24'h0000FF, l);
        blank(4);
        check("post_rst_pix", 32'(pv_total - p), 32'd0);
        vsync();
        check("post_rst_done", 32'(v_done), 32'd0);
        check("post_rst_lock", 32'(v_lock), 32'd0);
        p = pv_total;
        send_line(H, 24'h0000FF, 0);
        blank(3);
        check("resume_pix", 32'(pv_total - p), 32'(H));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
